// File: rtl/mem_responder.sv
// mem_responder: wait-stated word memory answering a memEn/MFC handshake with registered read data.
module mem_responder #(
    parameter int DATA_W      = 16,
    parameter int ADDR_W      = 16,
    parameter int DEPTH       = 256,
    parameter int WAIT_STATES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              memEn,
    input  logic              R_W,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              MFC,
    output logic              err
);
    localparam int IW = DEPTH > 1 ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] LIMIT = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} state_t;

    state_t            state, next;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] addr_q;
    logic              rw_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              in_range, go;
    logic [IW-1:0]     idx;

    assign in_range = {1'b0, addr_q} < LIMIT;
    assign go       = state == ACCESS && memEn;
    assign idx      = addr_q[IW-1:0];

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= IDLE;
        else       state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = memEn ? WAIT : IDLE;
            WAIT:    next = !memEn ? IDLE : (cnt == 4'd0 ? ACCESS : WAIT);
            ACCESS:  next = memEn ? DONE : IDLE;
            default: next = memEn ? DONE : IDLE;
        endcase
    end

    // Request fields are captured once so initiator changes mid-transaction are ignored
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            rw_q    <= 1'b0;
            wdata_q <= '0;
            rdata   <= '0;
            MFC     <= 1'b0;
            err     <= 1'b0;
        end else begin
            if (state == IDLE && memEn) begin
                cnt     <= 4'(WAIT_STATES);
                addr_q  <= addr;
                rw_q    <= R_W;
                wdata_q <= wdata;
            end
            if (state == WAIT && memEn && cnt != 4'd0) cnt <= cnt - 4'd1;
            if (go) begin
                MFC <= 1'b1;
                err <= !in_range;
                if (rw_q) rdata <= in_range ? mem[idx] : '0;
            end
            if (state == DONE && !memEn) begin
                MFC <= 1'b0;
                err <= 1'b0;
            end
        end
    end

    // Array has no reset; aborted or reset-interrupted writes never reach ACCESS
    always_ff @(posedge clk)
        if (go && !rw_q && in_range) mem[idx] <= wdata_q;
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter DATA_W, default 16, SHALL set the data word width.
REQ-002 Parameter ADDR_W, default 16, SHALL set the address width.
REQ-003 Parameter DEPTH, default 256, SHALL set the number of words in the array (DEPTH <= 2^ADDR_W).
REQ-004 Parameter WAIT_STATES, default 2, range 0..15, SHALL set the extra access latency in cycles.
REQ-005 clk  input  1  SHALL be the clock; all state changes occur on its rising edge.
REQ-006 reset  input  1  SHALL be the reset: asynchronous, active-high.
REQ-007 memEn  input  1  SHALL be the access request from the initiator, held high until MFC is seen.
REQ-008 R_W  input  1  SHALL select the access type: 1 = read, 0 = write.
REQ-009 addr  input  ADDR_W  SHALL be the word address, driven from MAR.
REQ-010 wdata  input  DATA_W  SHALL be the write data, driven from MDR.
REQ-011 rdata  output  DATA_W  SHALL be the read data toward MDR, registered.
REQ-012 MFC  output  1  SHALL be the memory-function-complete handshake, registered.
REQ-013 err  output  1  SHALL flag an out-of-range access and is valid only while MFC=1.

Function
REQ-014 The block SHALL implement the four states IDLE, WAIT, ACCESS and DONE, held in a registered state variable.
REQ-015 In IDLE with memEn=1 at an edge, the block SHALL latch addr, R_W and wdata, load wait counter = WAIT_STATES, and go to WAIT.
REQ-016 In IDLE with memEn=0, the block SHALL remain in IDLE.
REQ-017 In WAIT with memEn=1, the block SHALL go to ACCESS if counter==0, else decrement the counter and stay in WAIT.
REQ-018 In ACCESS with memEn=1, the block SHALL perform the latched operation, set MFC=1 and go to DONE.
REQ-019 A read in ACCESS SHALL load rdata with mem[addr].
REQ-020 A write in ACCESS SHALL set mem[addr]=wdata and leave rdata unchanged.
REQ-021 MFC SHALL first read 1 after edge E0+WAIT_STATES+2, where E0 is the IDLE sampling edge.
REQ-022 In DONE, MFC and rdata SHALL hold while memEn=1.
REQ-023 In DONE, the first edge with memEn=0 SHALL clear MFC and err and go to IDLE.
REQ-024 A new request SHALL start only from IDLE, so memEn must be seen low at least once between transactions.
REQ-025 Latched addr, R_W and wdata SHALL be used for the whole transaction; input changes after E0 SHALL be ignored.
REQ-026 If memEn=0 at an edge in WAIT or ACCESS (abort), the block SHALL go to IDLE with no memory write, MFC=0 and rdata unchanged.
REQ-027 If latched addr >= DEPTH, ACCESS SHALL assert err=1 with MFC=1, leave the array unchanged, and load rdata=0 on a read.
REQ-028 In-range accesses SHALL leave err=0.
REQ-029 rdata SHALL change only in ACCESS on a read, or on reset.
REQ-030 The array contents SHALL NOT be cleared by reset; contents before the first write are undefined.

Reset
REQ-031 Asserting reset SHALL immediately force state=IDLE, MFC=0, err=0, rdata=0 and counter=0, in any state.
REQ-032 A write in progress SHALL be discarded if reset arrives before its ACCESS edge.
REQ-033 After reset deasserts, the first rising edge with memEn=1 SHALL start a new transaction per REQ-015.

Verification
REQ-034 Write/readback (WAIT_STATES=2): write 0x1234 to addr 0x0010 -> MFC=1 after E0+4, err=0; drop memEn -> MFC=0 after next edge; then read 0x0010 -> rdata=0x1234 when MFC=1.
REQ-035 Zero wait (WAIT_STATES=0): read -> MFC=1 after E0+2; holding memEn high for 5 extra cycles -> MFC and rdata stable, no second access.
REQ-036 Out of range (DEPTH=256): write 0xBEEF to addr 0x0100, then read 0x0100 -> err=1 and rdata=0x0000 with MFC; a readback of 0x00FF is unaffected.
REQ-037 Abort: write 0x5555 to addr 0x0020 with memEn dropped in WAIT -> MFC never rises; a later read of 0x0020 returns the prior value.
REQ-038 Reset mid-operation: assert reset in DONE -> MFC=0, err=0, rdata=0 immediately, without a clock edge; a reset during WAIT of a write leaves that word unchanged.
REQ-039 Back-to-back: reads of 0x0001 and then 0x0002 with memEn low for one edge between them -> two distinct MFC pulses with the correct data.
